// File: rtl/locked_reg_bank.sv
// rtl/locked_reg_bank.sv - bank of lockable config registers with sticky locks and violation counting
// Optional build macro LOCKREG_DEBUG_OVERRIDE_EN: trusted debug writes may modify locked registers.
module locked_reg_bank #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 3,
    parameter int VIOL_W   = 8
) (
    input  logic                       Clk,
    input  logic                       resetn,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       lock_req,
    input  logic [ADDR_W-1:0]          lock_addr,
    input  logic                       lock_all,
    input  logic                       trusted,
    input  logic                       debug_mode,
    input  logic [ADDR_W-1:0]          rd_addr,
    output logic [DATA_W-1:0]          rd_data,
    output logic [NUM_REGS*DATA_W-1:0] regs_flat,
    output logic [NUM_REGS-1:0]        lock_status,
    output logic                       wr_ack,
    output logic                       wr_err,
    output logic [VIOL_W-1:0]          viol_count
);

    localparam logic [ADDR_W:0] NUM_REGS_W = (ADDR_W+1)'(NUM_REGS);

    logic [DATA_W-1:0] regs [NUM_REGS];

    logic wr_in_range;
    logic rd_in_range;
    logic wr_locked;
    logic override;
    logic wr_accept;
    logic wr_reject;

`ifdef LOCKREG_DEBUG_OVERRIDE_EN
    assign override = debug_mode & trusted;
`else
    logic unused_dbg;
    assign unused_dbg = debug_mode ^ trusted;
    assign override   = 1'b0;
`endif

    // A lock presented in the same cycle as a write takes effect before the write.
    always_comb begin
        wr_in_range = ({1'b0, wr_addr} < NUM_REGS_W);
        rd_in_range = ({1'b0, rd_addr} < NUM_REGS_W);
        wr_locked   = lock_all | (lock_req & (lock_addr == wr_addr));
        if (wr_in_range && lock_status[wr_addr])
            wr_locked = 1'b1;
        wr_accept   = wr_en & wr_in_range & (~wr_locked | override);
        wr_reject   = wr_en & ~wr_accept;
    end

    always_ff @(posedge Clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
            rd_data     <= '0;
            lock_status <= '0;
            wr_ack      <= 1'b0;
            wr_err      <= 1'b0;
            viol_count  <= '0;
        end else begin
            wr_ack <= wr_accept;
            wr_err <= wr_reject;
            if (wr_reject && (viol_count != '1))
                viol_count <= viol_count + 1'b1;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (lock_all || (lock_req && (lock_addr == ADDR_W'(i))))
                    lock_status[i] <= 1'b1;
                if (wr_accept && (wr_addr == ADDR_W'(i)))
                    regs[i] <= wr_data;
            end
            rd_data <= rd_in_range ? regs[rd_addr] : '0;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[g*DATA_W +: DATA_W] = regs[g];
    end

endmodule

// File: tb/tb_locked_reg_bank.sv
// tb/tb_locked_reg_bank.sv - directed table-driven bench for locked_reg_bank (NUM_REGS=6)
module tb_locked_reg_bank;

    logic        Clk = 1'b0;
    logic        resetn;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic        lock_req;
    logic [2:0]  lock_addr;
    logic        lock_all;
    logic        trusted;
    logic        debug_mode;
    logic [2:0]  rd_addr;
    logic [15:0] rd_data;
    logic [95:0] regs_flat;
    logic [5:0]  lock_status;
    logic        wr_ack;
    logic        wr_err;
    logic [7:0]  viol_count;

    int errors = 0;
    int checks = 0;

    always #5 Clk = ~Clk;

    locked_reg_bank #(.DATA_W(16), .NUM_REGS(6), .ADDR_W(3), .VIOL_W(8)) dut (
        .Clk(Clk), .resetn(resetn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .lock_req(lock_req), .lock_addr(lock_addr), .lock_all(lock_all), .trusted(trusted),
        .debug_mode(debug_mode), .rd_addr(rd_addr), .rd_data(rd_data), .regs_flat(regs_flat),
        .lock_status(lock_status), .wr_ack(wr_ack), .wr_err(wr_err), .viol_count(viol_count)
    );

    typedef struct {
        logic        we;
        logic [2:0]  wa;
        logic [15:0] wd;
        logic        lr;
        logic [2:0]  la;
        logic        lall;
        logic        tr;
        logic        dbg;
        logic [2:0]  ra;
        logic        ack;
        logic        err;
        logic [15:0] rd;
        logic [5:0]  lock;
        logic [7:0]  viol;
    } vec_t;

    vec_t tv[15];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        wr_en = 0; wr_addr = 0; wr_data = 0; lock_req = 0; lock_addr = 0;
        lock_all = 0; trusted = 0; debug_mode = 0; rd_addr = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " rd_data"}, 128'(rd_data), 128'd0);
        check({tag, " regs_flat"}, 128'(regs_flat), 128'd0);
        check({tag, " lock_status"}, 128'(lock_status), 128'd0);
        check({tag, " wr_ack"}, 128'(wr_ack), 128'd0);
        check({tag, " wr_err"}, 128'(wr_err), 128'd0);
        check({tag, " viol_count"}, 128'(viol_count), 128'd0);
    endtask

    initial begin
        logic        ovr;
        logic [15:0] r2_final;
        logic [7:0]  v8;
        logic [95:0] exp_flat;
        int          ack_seen;
        int          err_cnt;

`ifdef LOCKREG_DEBUG_OVERRIDE_EN
        ovr = 1'b1;
`else
        ovr = 1'b0;
`endif
        r2_final = ovr ? 16'hBEEF : 16'hA5A5;
        v8 = ovr ? 8'd3 : 8'd4;

        //        we wa  wd         lr la  lall tr dbg ra   ack   err   rd           lock   viol
        tv[0]  = '{1, 2, 16'hA5A5, 0, 0, 0, 0, 0, 2, 1'b1, 1'b0, 16'h0000, 6'h00, 8'd0};
        tv[1]  = '{0, 0, 16'h0000, 0, 0, 0, 0, 0, 2, 1'b0, 1'b0, 16'hA5A5, 6'h00, 8'd0};
        tv[2]  = '{0, 0, 16'h0000, 1, 2, 0, 0, 0, 2, 1'b0, 1'b0, 16'hA5A5, 6'h04, 8'd0};
        tv[3]  = '{1, 2, 16'h1234, 0, 0, 0, 0, 0, 2, 1'b0, 1'b1, 16'hA5A5, 6'h04, 8'd1};
        tv[4]  = '{0, 0, 16'h0000, 0, 0, 0, 0, 0, 2, 1'b0, 1'b0, 16'hA5A5, 6'h04, 8'd1};
        tv[5]  = '{1, 3, 16'h5555, 1, 3, 0, 0, 0, 3, 1'b0, 1'b1, 16'h0000, 6'h0C, 8'd2};
        tv[6]  = '{0, 0, 16'h0000, 0, 0, 0, 0, 0, 3, 1'b0, 1'b0, 16'h0000, 6'h0C, 8'd2};
        tv[7]  = '{1, 2, 16'hBEEF, 0, 0, 0, 0, 1, 2, 1'b0, 1'b1, 16'hA5A5, 6'h0C, 8'd3};
        tv[8]  = '{1, 2, 16'hBEEF, 0, 0, 0, 1, 1, 2, ovr,  ~ovr, 16'hA5A5, 6'h0C, v8};
        tv[9]  = '{0, 0, 16'h0000, 0, 0, 0, 0, 0, 2, 1'b0, 1'b0, r2_final, 6'h0C, v8};
        tv[10] = '{1, 7, 16'h7777, 0, 0, 0, 0, 0, 7, 1'b0, 1'b1, 16'h0000, 6'h0C, v8 + 8'd1};
        tv[11] = '{1, 0, 16'h1111, 0, 0, 0, 0, 1, 0, 1'b1, 1'b0, 16'h0000, 6'h0C, v8 + 8'd1};
        tv[12] = '{0, 0, 16'h0000, 1, 7, 0, 0, 0, 0, 1'b0, 1'b0, 16'h1111, 6'h0C, v8 + 8'd1};
        tv[13] = '{1, 5, 16'h2222, 0, 0, 0, 0, 0, 5, 1'b1, 1'b0, 16'h0000, 6'h0C, v8 + 8'd1};
        tv[14] = '{0, 0, 16'h0000, 0, 0, 0, 0, 0, 5, 1'b0, 1'b0, 16'h2222, 6'h0C, v8 + 8'd1};

        idle_inputs();
        resetn = 0;
        repeat (2) @(negedge Clk);
        check_all_zero("reset");
        resetn = 1;

        for (int i = 0; i < 15; i++) begin
            wr_en = tv[i].we; wr_addr = tv[i].wa; wr_data = tv[i].wd;
            lock_req = tv[i].lr; lock_addr = tv[i].la; lock_all = tv[i].lall;
            trusted = tv[i].tr; debug_mode = tv[i].dbg; rd_addr = tv[i].ra;
            @(posedge Clk);
            @(negedge Clk);
            check($sformatf("v%0d wr_ack", i), 128'(wr_ack), 128'(tv[i].ack));
            check($sformatf("v%0d wr_err", i), 128'(wr_err), 128'(tv[i].err));
            check($sformatf("v%0d rd_data", i), 128'(rd_data), 128'(tv[i].rd));
            check($sformatf("v%0d lock_status", i), 128'(lock_status), 128'(tv[i].lock));
            check($sformatf("v%0d viol_count", i), 128'(viol_count), 128'(tv[i].viol));
        end

        exp_flat = {16'h2222, 16'h0000, 16'h0000, r2_final, 16'h0000, 16'h1111};
        check("regs_flat after table", 128'(regs_flat), 128'(exp_flat));

        // lock_all, then a long burst of rejected writes saturating the counter
        idle_inputs();
        lock_all = 1;
        @(posedge Clk);
        @(negedge Clk);
        check("lock_all status", 128'(lock_status), 128'h3F);
        lock_all = 0;
        ack_seen = 0;
        err_cnt  = 0;
        for (int i = 0; i < 300; i++) begin
            wr_en = 1; wr_addr = 3'(i % 6); wr_data = 16'(i);
            @(posedge Clk);
            @(negedge Clk);
            if (wr_ack) ack_seen++;
            if (wr_err) err_cnt++;
        end
        check("burst acks", 128'(ack_seen), 128'd0);
        check("burst errs", 128'(err_cnt), 128'd300);
        check("viol saturated", 128'(viol_count), 128'd255);
        check("burst regs unchanged", 128'(regs_flat), 128'(exp_flat));

        // asynchronous reset between edges with a write still requested
        #2 resetn = 0;
        #1 check_all_zero("async reset");
        @(posedge Clk);
        @(negedge Clk);
        check_all_zero("held reset");
        idle_inputs();
        resetn = 1;
        @(posedge Clk);
        @(negedge Clk);
        check_all_zero("after reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    always @(negedge Clk) begin
        if (resetn && wr_ack && wr_err) begin
            errors++;
            $display("FAIL ack_err_exclusive: got both high, expected at most one");
        end
    end

endmodule
